// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its control decoder.
// Optional build macro: IFU_MISALIGN_CHECK_EN adds the ERR state.
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EXEC = 3'd3,
        HALT = 3'd4
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        ERR  = 3'd5
`endif
    } ifu_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] NOP_INST            = 32'h0000_0013;

    // Encoding of the decoder's PC-source select.
    localparam logic PC_FROM_SNPC = 1'b0;
    localparam logic PC_FROM_ALU  = 1'b1;

    // Jump targets always have bit 0 cleared (jalr semantics).
    function automatic logic [31:0] align_target(input logic [31:0] target);
        return {target[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection: sequential PC, jump target and misalignment flag.
// Optional build macro: IFU_MISALIGN_CHECK_EN exposes the misalign output.
module ifu_next_pc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] alu_target,
    output logic [31:0] snpc,
    output logic [31:0] next_pc
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        misalign
`endif
);

    // Wraps modulo 2^32 by construction.
    assign snpc    = pc + 32'd4;
    assign next_pc = (pc_src == PC_FROM_ALU) ? align_target(alu_target) : snpc;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign = (pc_src == PC_FROM_ALU) && alu_target[1];
`endif

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and holds it until acknowledged.
// Optional build macro: IFU_MISALIGN_CHECK_EN traps misaligned jump targets into a sticky ERR state.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [31:0] EBREAK_INST = DEFAULT_EBREAK_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        mem_resp_ready,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ack,
    input  logic        pc_src,
    input  logic [31:0] alu_target,
    output logic [31:0] pc,
    output logic [31:0] snpc,
    output logic        halt,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic        fetch_err,
`endif
    output ifu_state_t  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. A requester holds valid and its payload stable until that edge; ready
    // here is decoded from state only, so no input ever reaches an output in the
    // same cycle. The memory answers no earlier than the cycle after acceptance.

    ifu_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] snpc_w;
    logic [31:0] next_pc_w;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        misalign_w;
`endif

    ifu_next_pc u_next_pc (
        .pc         (pc_q),
        .pc_src     (pc_src),
        .alu_target (alu_target),
        .snpc       (snpc_w),
        .next_pc    (next_pc_w)
`ifdef IFU_MISALIGN_CHECK_EN
        ,
        .misalign   (misalign_w)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    inst_d  = mem_resp_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (inst_ack) begin
                    // ebreak wins over any jump decoding that came with it
                    if (inst_q == EBREAK_INST) begin
                        state_d = HALT;
`ifdef IFU_MISALIGN_CHECK_EN
                    end else if (misalign_w) begin
                        pc_d    = next_pc_w;
                        state_d = ERR;
`endif
                    end else begin
                        pc_d    = next_pc_w;
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
`ifdef IFU_MISALIGN_CHECK_EN
            ERR: state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = pc_q;
    assign mem_resp_ready = (state_q == WAIT);
    assign inst           = inst_q;
    assign inst_valid     = (state_q == EXEC);
    assign pc             = pc_q;
    assign snpc           = snpc_w;
    assign halt           = (state_q == HALT);
`ifdef IFU_MISALIGN_CHECK_EN
    assign fetch_err      = (state_q == ERR);
`endif
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: randomized memory/datapath stimulus against a transaction-level model.
// Build with IFU_MISALIGN_CHECK_EN defined to exercise the misalignment trap.
module tb_inst_fetch_unit;
    import ifu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        mem_resp_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ack = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] alu_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        halt;
`ifdef IFU_MISALIGN_CHECK_EN
    logic        fetch_err;
`endif
    ifu_state_t  state_dbg;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_ready (mem_resp_ready),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .inst_ack       (inst_ack),
        .pc_src         (pc_src),
        .alu_target     (alu_target),
        .pc             (pc),
        .snpc           (snpc),
        .halt           (halt),
`ifdef IFU_MISALIGN_CHECK_EN
        .fetch_err      (fetch_err),
`endif
        .state_dbg      (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_en = 1'b0;

    logic [31:0] exp_q[$];   // expected request addresses, predicted by the stimulus
    logic [31:0] tb_pc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Tracks what the unit must present, driven only by handshakes the bench observes.
    logic [31:0] m_pc, m_inst;
    logic        m_boot, m_req, m_rsp, m_iv, m_halt, m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= RST_PC; m_inst <= NOP; m_boot <= 1'b1;
            m_req <= 1'b0; m_rsp <= 1'b0; m_iv <= 1'b0; m_halt <= 1'b0; m_err <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0;
            m_req  <= 1'b1;
        end else if (m_req && mem_req_ready) begin
            m_req <= 1'b0;
            m_rsp <= 1'b1;
        end else if (m_rsp && mem_resp_valid) begin
            m_rsp  <= 1'b0;
            m_iv   <= 1'b1;
            m_inst <= mem_resp_data;
        end else if (m_iv && inst_ack) begin
            m_iv <= 1'b0;
            if (m_inst == EBRK) begin
                m_halt <= 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
            end else if (pc_src && alu_target[1]) begin
                m_pc  <= alu_target & 32'hFFFF_FFFE;
                m_err <= 1'b1;
`endif
            end else begin
                m_pc  <= pc_src ? (alu_target & 32'hFFFF_FFFE) : m_pc + 32'd4;
                m_req <= 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check32("mem_req_valid", 32'(mem_req_valid), 32'(m_req));
            check32("mem_req_addr", mem_req_addr, m_pc);
            check32("mem_resp_ready", 32'(mem_resp_ready), 32'(m_rsp));
            check32("inst_valid", 32'(inst_valid), 32'(m_iv));
            check32("inst", inst, m_inst);
            check32("pc", pc, m_pc);
            check32("snpc", snpc, m_pc + 32'd4);
            check32("halt", 32'(halt), 32'(m_halt));
`ifdef IFU_MISALIGN_CHECK_EN
            check32("fetch_err", 32'(fetch_err), 32'(m_err));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        check32("rst_state", 32'(state_dbg), 32'(IDLE));
        check32("rst_pc", pc, RST_PC);
        check32("rst_inst", inst, NOP);
        check32("rst_req_valid", 32'(mem_req_valid), 32'h0);
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        tb_pc = RST_PC;
    endtask

    // Memory side: accept after rdly cycles, answer sdly cycles later, hold the response rhold cycles.
    task automatic do_fetch(input logic [31:0] word, input int rdly, input int sdly, input int rhold);
        int          n = 0;
        logic [31:0] a;
        while (mem_req_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (mem_req_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL req_timeout: got mem_req_valid=%b expected 1 at %0t", mem_req_valid, $time);
            return;
        end
        if (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            check32("req_addr_sb", mem_req_addr, a);
        end
        for (int i = 0; i < rdly; i++) begin
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = $urandom;
            inst_ack       = 1'($urandom_range(0, 1));
            step();
        end
        mem_resp_valid = 1'b0;
        inst_ack       = 1'b0;
        mem_req_ready  = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        repeat (sdly) step();
        for (int i = 0; i < rhold; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = (i == 0) ? word : $urandom;
            step();
        end
        mem_resp_valid = 1'b0;
    endtask

    // Datapath side: acknowledge after dly cycles with the given PC source.
    task automatic do_ack(input logic src, input logic [31:0] tgt, input int dly, input bit push);
        int n = 0;
        while (inst_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        n_cmp++;
        if (inst_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ack_timeout: got inst_valid=%b expected 1 at %0t", inst_valid, $time);
            return;
        end
        for (int i = 0; i < dly; i++) begin
            pc_src     = 1'($urandom_range(0, 1));
            alu_target = $urandom;
            step();
        end
        pc_src     = src;
        alu_target = tgt;
        inst_ack   = 1'b1;
        step();
        inst_ack   = 1'b0;
        if (push) begin
            tb_pc = src ? (tgt & 32'hFFFF_FFFE) : tb_pc + 32'd4;
            exp_q.push_back(tb_pc);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] w;
        logic [31:0] t;
        int          n;

        do_reset();
        step();
        check32("req_rise", 32'(mem_req_valid), 32'h1);
        check32("first_addr", mem_req_addr, 32'h8000_0000);

        // straight-line nops, zero-wait memory
        do_fetch(NOP, 0, 0, 1);
        check32("iv_rise", 32'(inst_valid), 32'h1);
        do_ack(1'b0, 32'h0, 0, 1);
        do_fetch(NOP, 0, 0, 1);
        check32("pc_seq", pc, 32'h8000_0004);
        do_ack(1'b0, 32'h0, 0, 1);
        do_fetch(NOP, 0, 0, 1);
        do_ack(1'b0, 32'h0, 1, 1);
        do_fetch(NOP, 0, 1, 1);
        do_ack(1'b0, 32'h0, 0, 1);

        // jal at 0x8000_0010
        do_fetch(32'h0f00_00ef, 0, 0, 1);
        check32("jal_pc", pc, 32'h8000_0010);
        check32("jal_snpc", snpc, 32'h8000_0014);
        do_ack(1'b1, 32'h8000_0101, 0, 1);

        // slow accept, then a 3-cycle response burst with changing data
        do_fetch(32'h00a0_0093, 5, 0, 3);
        check32("burst_pc", pc, 32'h8000_0100);
        check32("burst_inst", inst, 32'h00a0_0093);
        do_ack(1'b0, 32'h0, 0, 1);

        // wrap-around of the sequential PC
        do_fetch(NOP, 0, 0, 1);
        do_ack(1'b1, 32'hFFFF_FFFC, 0, 1);
        do_fetch(NOP, 1, 0, 1);
        check32("wrap_snpc", snpc, 32'h0000_0000);
        do_ack(1'b0, 32'h0, 0, 1);
        do_fetch(NOP, 0, 0, 1);
        check32("wrap_pc", pc, 32'h0000_0000);
        do_ack(1'b1, 32'h8000_0200, 0, 1);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            if (w == EBRK) w = NOP;
            t = $urandom & 32'hFFFF_FFFD;
            do_fetch(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 2));
            do_ack(1'($urandom_range(0, 1)), t, $urandom_range(0, 3), 1);
        end

        // reset while a response is outstanding
        n = 0;
        while (mem_req_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        check32("wait_resp_ready", 32'(mem_resp_ready), 32'h1);
        rst = 1'b1;
        step();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        step();
        rst = 1'b0;
        step();
        step();
        mem_resp_valid = 1'b0;
        check32("rstw_inst", inst, NOP);
        check32("rstw_pc", pc, RST_PC);
        check32("rstw_req", 32'(mem_req_valid), 32'h1);
        exp_q.delete();
        exp_q.push_back(RST_PC);
        tb_pc = RST_PC;

        // misaligned jump target
        do_fetch(NOP, 0, 0, 1);
`ifdef IFU_MISALIGN_CHECK_EN
        do_ack(1'b1, 32'h8000_0006, 0, 0);
        check32("mis_err", 32'(fetch_err), 32'h1);
        check32("mis_pc", pc, 32'h8000_0006);
        for (int i = 0; i < 10; i++) begin
            mem_req_ready = 1'($urandom_range(0, 1));
            inst_ack      = 1'($urandom_range(0, 1));
            step();
            check32("mis_no_req", 32'(mem_req_valid), 32'h0);
        end
        mem_req_ready = 1'b0;
        inst_ack      = 1'b0;
        do_reset();
`else
        do_ack(1'b1, 32'h8000_0006, 0, 1);
        do_fetch(NOP, 0, 0, 1);
        check32("mis_pc", pc, 32'h8000_0006);
        do_ack(1'b0, 32'h0, 0, 1);
`endif

        // ebreak halts fetching for good
        do_fetch(EBRK, 0, 1, 1);
        do_ack(1'b0, 32'h0, 0, 0);
        check32("halt_set", 32'(halt), 32'h1);
        for (int i = 0; i < 20; i++) begin
            inst_ack       = 1'($urandom_range(0, 1));
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = $urandom;
            step();
            check32("halt_no_req", 32'(mem_req_valid), 32'h0);
        end
        inst_ack       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
